// File: rtl/p405s_icu_va_queue.sv
// ICU fetch virtual-address queue: DEPTH-entry FIFO of fetch addresses
// with registered-storage head, push/pop/flush and dropped-push flag.
module p405s_icu_va_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             CB,
  input  logic             resetCore,
  input  logic [0:WIDTH-1] D,
  input  logic             E1,
  input  logic             popReq,
  input  logic             flush,
  output logic [0:WIDTH-1] L2,
  output logic             valid,
  output logic             full,
  output logic [AW:0]      count,
  output logic             ovfl
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [0:WIDTH-1] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_acc;
  logic             push_acc;

  assign valid    = (count != '0);
  assign full     = (count == DEPTH_C);
  assign pop_acc  = popReq & valid;
  assign push_acc = E1 & (~full | pop_acc);
  assign L2       = valid ? mem[rd_ptr] : '0;

  // Storage is deliberately left out of reset; valid gates the head.
  always_ff @(posedge CB) begin
    if (push_acc && !flush) begin
      mem[wr_ptr] <= D;
    end
  end

  always_ff @(posedge CB or posedge resetCore) begin
    if (resetCore) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovfl   <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovfl   <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ovfl <= E1 & full & ~pop_acc;
    end
  end

endmodule

// File: tb/tb_p405s_icu_va_queue.sv
// Bench for p405s_icu_va_queue: DEPTH 2/4/16 instances on shared inputs,
// checked against per-instance queue models.
module tb_p405s_icu_va_queue;

  logic        CB = 1'b0;
  logic        resetCore;
  logic [31:0] D;
  logic        E1;
  logic        popReq;
  logic        flush;

  logic [31:0] l2_a, l2_b, l2_c;
  logic        v_a, v_b, v_c;
  logic        f_a, f_b, f_c;
  logic        o_a, o_b, o_c;
  logic [1:0]  cnt_a;
  logic [2:0]  cnt_b;
  logic [4:0]  cnt_c;

  logic [31:0] obs_l2 [3];
  logic [31:0] obs_cnt [3];
  logic        obs_v [3];
  logic        obs_f [3];
  logic        obs_o [3];

  int          dep [3] = '{2, 4, 16};
  logic [31:0] mq [3][$];
  bit          m_ovfl [3];

  int checks = 0;
  int failures = 0;

  always #5 CB = ~CB;

  p405s_icu_va_queue #(.WIDTH(32), .DEPTH(2), .AW(1)) u_d2 (
    .CB(CB), .resetCore(resetCore), .D(D), .E1(E1), .popReq(popReq),
    .flush(flush), .L2(l2_a), .valid(v_a), .full(f_a), .count(cnt_a),
    .ovfl(o_a));

  p405s_icu_va_queue #(.WIDTH(32), .DEPTH(4), .AW(2)) u_d4 (
    .CB(CB), .resetCore(resetCore), .D(D), .E1(E1), .popReq(popReq),
    .flush(flush), .L2(l2_b), .valid(v_b), .full(f_b), .count(cnt_b),
    .ovfl(o_b));

  p405s_icu_va_queue #(.WIDTH(32), .DEPTH(16), .AW(4)) u_d16 (
    .CB(CB), .resetCore(resetCore), .D(D), .E1(E1), .popReq(popReq),
    .flush(flush), .L2(l2_c), .valid(v_c), .full(f_c), .count(cnt_c),
    .ovfl(o_c));

  assign obs_l2[0] = l2_a;
  assign obs_l2[1] = l2_b;
  assign obs_l2[2] = l2_c;
  assign obs_cnt[0] = 32'(cnt_a);
  assign obs_cnt[1] = 32'(cnt_b);
  assign obs_cnt[2] = 32'(cnt_c);
  assign obs_v[0] = v_a;
  assign obs_v[1] = v_b;
  assign obs_v[2] = v_c;
  assign obs_f[0] = f_a;
  assign obs_f[1] = f_b;
  assign obs_f[2] = f_c;
  assign obs_o[0] = o_a;
  assign obs_o[1] = o_b;
  assign obs_o[2] = o_c;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] hd;
      int n;
      n  = mq[k].size();
      hd = (n > 0) ? mq[k][0] : 32'h0;
      chk($sformatf("d%0d_count", dep[k]), obs_cnt[k], 32'(n));
      chk($sformatf("d%0d_valid", dep[k]), 32'(obs_v[k]), 32'(n != 0));
      chk($sformatf("d%0d_full", dep[k]), 32'(obs_f[k]),
          32'(n == dep[k]));
      chk($sformatf("d%0d_ovfl", dep[k]), 32'(obs_o[k]),
          32'(m_ovfl[k]));
      chk($sformatf("d%0d_l2", dep[k]), obs_l2[k], hd);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      m_ovfl[k] = 1'b0;
    end
  endtask

  // One clock: apply inputs, advance models at the edge, check after.
  task automatic step(input logic [31:0] d, input bit e, input bit p,
                      input bit f);
    D = d;
    E1 = e;
    popReq = p;
    flush = f;
    @(posedge CB);
    for (int k = 0; k < 3; k++) begin
      bit is_full, pop_ok, push_ok;
      is_full = (mq[k].size() == dep[k]);
      pop_ok  = p && (mq[k].size() > 0);
      if (f) begin
        mq[k].delete();
        m_ovfl[k] = 1'b0;
      end else begin
        push_ok   = e && (!is_full || pop_ok);
        m_ovfl[k] = e && is_full && !pop_ok;
        if (pop_ok) void'(mq[k].pop_front());
        if (push_ok) mq[k].push_back(d);
      end
    end
    #1;
    E1 = 1'b0;
    popReq = 1'b0;
    flush = 1'b0;
    check_all();
  endtask

  initial begin
    resetCore = 1'b1;
    D = '0;
    E1 = 1'b0;
    popReq = 1'b0;
    flush = 1'b0;
    model_clear();
    #2;
    check_all();
    #10 resetCore = 1'b0;
    @(posedge CB);
    #1;
    check_all();

    // async reset with two entries held
    step(32'h0000_0A00, 1, 0, 0);
    step(32'h0000_0A04, 1, 0, 0);
    chk("pre_rst_count", obs_cnt[1], 32'd2);
    #3 resetCore = 1'b1;
    #1;
    model_clear();
    chk("rst_async_valid", 32'(v_b), 32'd0);
    chk("rst_async_l2", l2_b, 32'h0);
    check_all();
    #1 resetCore = 1'b0;
    step(32'h0, 0, 1, 0);

    // fill and drain
    step(32'h1000, 1, 0, 0);
    step(32'h1004, 1, 0, 0);
    step(32'h1008, 1, 0, 0);
    step(32'h100C, 1, 0, 0);
    chk("fill_full", 32'(f_b), 32'd1);
    chk("fill_l2", l2_b, 32'h1000);
    step(32'h0, 0, 1, 0);
    chk("drain1", l2_b, 32'h1004);
    step(32'h0, 0, 1, 0);
    chk("drain2", l2_b, 32'h1008);
    step(32'h0, 0, 1, 0);
    chk("drain3", l2_b, 32'h100C);
    step(32'h0, 0, 1, 0);
    chk("drain4", l2_b, 32'h0);

    // overflow, then push+pop while full
    for (int i = 0; i < 4; i++) step(32'h5000 + 32'(i * 4), 1, 0, 0);
    step(32'hDEAD_0000, 1, 0, 0);
    chk("ovfl_set", 32'(o_b), 32'd1);
    chk("ovfl_count", obs_cnt[1], 32'd4);
    step(32'h0, 0, 0, 0);
    chk("ovfl_pulse", 32'(o_b), 32'd0);
    step(32'h2000, 1, 1, 0);
    chk("pp_full_count", obs_cnt[1], 32'd4);
    chk("pp_full_l2", l2_b, 32'h5004);
    for (int i = 0; i < 4; i++) step(32'h0, 0, 1, 0);

    // wrap-around: alternate push and pop
    for (int i = 0; i < 10; i++) begin
      step(32'(i * 4), 1, 0, 0);
      step(32'h0, 0, 1, 0);
    end

    // same-cycle push+pop on empty
    step(32'h6000, 1, 1, 0);
    chk("pp_empty_l2", l2_b, 32'h6000);
    step(32'h0, 0, 1, 0);

    // flush priority
    step(32'h7000, 1, 0, 0);
    step(32'h7004, 1, 0, 0);
    step(32'h7008, 1, 0, 0);
    step(32'h3000, 1, 1, 1);
    chk("flush_count", obs_cnt[1], 32'd0);
    chk("flush_l2", l2_b, 32'h0);
    step(32'h4000, 1, 0, 0);
    chk("post_flush_l2", l2_b, 32'h4000);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
